// File: rtl/bus_load_unit_pkg.sv
// Shared constants and types for the bus load unit: load/inc/clear select
// bit positions (matching the bus-mux select encoding), error flag
// positions and the DRAM write state type.
package bus_load_unit_pkg;

   // load_ctrl one-hot bit positions
   localparam int LD_R    = 0;
   localparam int LD_AR   = 1;
   localparam int LD_DR   = 2;
   localparam int LD_AC   = 3;
   localparam int LD_PC   = 4;
   localparam int LD_IR   = 5;
   localparam int LD_DRAM = 6;
   localparam int LD_IRAM = 7;

   // inc_ctrl bit positions
   localparam int INC_PC = 0;
   localparam int INC_AR = 1;
   localparam int INC_R  = 2;

   // clr_ctrl bit positions
   localparam int CLR_AC = 0;
   localparam int CLR_R  = 1;

   // sticky err bit positions
   localparam int ERR_MULTI   = 0;
   localparam int ERR_IRAM    = 1;
   localparam int ERR_BUSY    = 2;
   localparam int ERR_TIMEOUT = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wr_state_e;

endpackage

// File: rtl/bus_load_unit_if.sv
// Bus-side signal bundle of the load unit: bus value and control words in,
// register contents, DRAM write port and error flags out.
interface bus_load_unit_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] bus_data;
   logic [7:0]       load_ctrl;
   logic [2:0]       inc_ctrl;
   logic [1:0]       clr_ctrl;
   logic             dram_ack;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] ar;
   logic [WIDTH-1:0] dr;
   logic [WIDTH-1:0] ac;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] ir;
   logic [WIDTH-1:0] dram_addr;
   logic [WIDTH-1:0] dram_wdata;
   logic             dram_we;
   logic             busy;
   logic [3:0]       err;

   modport master (
      output bus_data, load_ctrl, inc_ctrl, clr_ctrl, dram_ack,
      input  r, ar, dr, ac, pc, ir, dram_addr, dram_wdata, dram_we, busy, err
   );

   modport slave (
      input  bus_data, load_ctrl, inc_ctrl, clr_ctrl, dram_ack,
      output r, ar, dr, ac, pc, ir, dram_addr, dram_wdata, dram_we, busy, err
   );
endinterface

// File: rtl/bus_load_unit_dram_write_ctrl.sv
// DRAM write handshake: captures address/data on start, holds the write
// strobe until ack, and aborts with a one-cycle timeout pulse when the ack
// never arrives within ACK_TIMEOUT+1 strobe cycles.
module dram_write_ctrl
   import bus_load_unit_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] addr_in_i,
   input  logic [WIDTH-1:0] data_in_i,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             we_o,
   output logic             timeout_pulse_o,
   output logic [WIDTH-1:0] addr_o,
   output logic [WIDTH-1:0] data_o
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

   wr_state_e        state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] data_q, data_d;

   // State, timeout counter and captured address/data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Next state: ack wins over timeout when both land on the same edge
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      addr_d          = addr_q;
      data_d          = data_q;
      timeout_pulse_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = WRITE;
               cnt_d   = '0;
               addr_d  = addr_in_i;
               data_d  = data_in_i;
            end
         end
         WRITE: begin
            if (ack_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_CNT) begin
               state_d         = IDLE;
               cnt_d           = '0;
               timeout_pulse_o = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q == WRITE);
   assign we_o   = (state_q == WRITE);
   assign addr_o = addr_q;
   assign data_o = data_q;

endmodule

// File: rtl/bus_load_unit.sv
// Destination side of the shared data bus: register bank with load,
// increment and clear micro-ops, DRAM write launch and sticky error flags.
module bus_load_unit
   import bus_load_unit_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] PC_RESET    = '0,
   parameter int               ACK_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   bus_load_unit_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_q, r_d, ar_q, ar_d, dr_q, dr_d;
   logic [WIDTH-1:0] ac_q, ac_d, pc_q, pc_d, ir_q, ir_d;
   logic [3:0]       err_q, err_d;
   logic [3:0]       hotCount;
   logic [7:0]       ldSel;
   logic             multiHot;
   logic             wrStart;
   logic             wrBusy;
   logic             wrWe;
   logic             wrTimeout;
   logic [WIDTH-1:0] wrAddr, wrData;

   // Register bank and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= '0;
         ar_q  <= '0;
         dr_q  <= '0;
         ac_q  <= '0;
         pc_q  <= PC_RESET;
         ir_q  <= '0;
         err_q <= '0;
      end else begin
         r_q   <= r_d;
         ar_q  <= ar_d;
         dr_q  <= dr_d;
         ac_q  <= ac_d;
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         err_q <= err_d;
      end
   end

   // Decode the load word; per register, clear beats load beats increment
   always_comb begin
      hotCount = 4'($countones(bus.load_ctrl));
      multiHot = (hotCount > 4'd1);
      ldSel    = (hotCount == 4'd1) ? bus.load_ctrl : 8'h00;
      wrStart  = ldSel[LD_DRAM] & ~wrBusy;

      r_d  = r_q;
      ar_d = ar_q;
      dr_d = dr_q;
      ac_d = ac_q;
      pc_d = pc_q;
      ir_d = ir_q;

      if (bus.clr_ctrl[CLR_R])      r_d = '0;
      else if (ldSel[LD_R])         r_d = bus.bus_data;
      else if (bus.inc_ctrl[INC_R]) r_d = r_q + ONE;

      if (ldSel[LD_AR])              ar_d = bus.bus_data;
      else if (bus.inc_ctrl[INC_AR]) ar_d = ar_q + ONE;

      if (ldSel[LD_DR]) dr_d = bus.bus_data;

      if (bus.clr_ctrl[CLR_AC]) ac_d = '0;
      else if (ldSel[LD_AC])    ac_d = bus.bus_data;

      if (ldSel[LD_PC])              pc_d = bus.bus_data;
      else if (bus.inc_ctrl[INC_PC]) pc_d = pc_q + ONE;

      if (ldSel[LD_IR]) ir_d = bus.bus_data;

      err_d = err_q;
      if (multiHot)                  err_d[ERR_MULTI]   = 1'b1;
      if (ldSel[LD_IRAM])            err_d[ERR_IRAM]    = 1'b1;
      if (ldSel[LD_DRAM] && wrBusy)  err_d[ERR_BUSY]    = 1'b1;
      if (wrTimeout)                 err_d[ERR_TIMEOUT] = 1'b1;
   end

   dram_write_ctrl #(
      .WIDTH       (WIDTH),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_dram_write_ctrl (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (wrStart),
      .addr_in_i       (ar_q),
      .data_in_i       (bus.bus_data),
      .ack_i           (bus.dram_ack),
      .busy_o          (wrBusy),
      .we_o            (wrWe),
      .timeout_pulse_o (wrTimeout),
      .addr_o          (wrAddr),
      .data_o          (wrData)
   );

   assign bus.r          = r_q;
   assign bus.ar         = ar_q;
   assign bus.dr         = dr_q;
   assign bus.ac         = ac_q;
   assign bus.pc         = pc_q;
   assign bus.ir         = ir_q;
   assign bus.dram_addr  = wrAddr;
   assign bus.dram_wdata = wrData;
   assign bus.dram_we    = wrWe;
   assign bus.busy       = wrBusy;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_bus_load_unit.sv
// Testbench for bus_load_unit: fixed vector table, hand-written write
// handshake / timeout / async reset sequences, then randomized traffic
// compared every cycle against a behavioural model.
module tb_bus_load_unit;
   import bus_load_unit_pkg::*;

   localparam int          W   = 16;
   localparam logic [15:0] PCR = 16'h0000;
   localparam int          TO  = 15;

   logic clk;
   logic rst_n;

   bus_load_unit_if #(.WIDTH(W)) bif ();

   bus_load_unit #(
      .WIDTH       (W),
      .PC_RESET    (PCR),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int checks = 0;
   int errors = 0;

   // Model state: registers indexed by load bit (R,AR,DR,AC,PC,IR)
   logic [15:0] mReg [6];
   logic [3:0]  mErr;
   logic        mWr;
   int          mAge;
   logic [15:0] mAddr;
   logic [15:0] mData;

   typedef struct {
      logic [15:0] busV;
      logic [7:0]  ld;
      logic [2:0]  inc;
      logic [1:0]  clr;
      logic [15:0] eR;
      logic [15:0] eAr;
      logic [15:0] eDr;
      logic [15:0] eAc;
      logic [15:0] ePc;
      logic [3:0]  eErr;
   } vec_t;

   vec_t vecs [11];

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 6; k++) mReg[k] = 16'h0000;
      mReg[LD_PC] = PCR;
      mErr  = 4'h0;
      mWr   = 1'b0;
      mAge  = 0;
      mAddr = 16'h0000;
      mData = 16'h0000;
   endtask

   // One clock edge of the unit described from its behavioural rules
   task automatic modelStep(input logic [15:0] busV, input logic [7:0] ld,
                            input logic [2:0] inc, input logic [1:0] clr, input logic ack);
      logic [15:0] nxt [6];
      int          ones;
      logic        wasWr;
      logic [15:0] oldAr;
      nxt   = mReg;
      wasWr = mWr;
      oldAr = mReg[LD_AR];
      ones  = $countones(ld);
      if (inc[0]) nxt[LD_PC] = mReg[LD_PC] + 16'd1;
      if (inc[1]) nxt[LD_AR] = mReg[LD_AR] + 16'd1;
      if (inc[2]) nxt[LD_R]  = mReg[LD_R] + 16'd1;
      if (ones == 1) begin
         for (int k = 0; k < 6; k++) if (ld[k]) nxt[k] = busV;
      end
      if (clr[0]) nxt[LD_AC] = 16'h0000;
      if (clr[1]) nxt[LD_R]  = 16'h0000;
      if (ones > 1) mErr[ERR_MULTI] = 1'b1;
      else if (ld == 8'h80) mErr[ERR_IRAM] = 1'b1;
      else if (ld == 8'h40 && wasWr) mErr[ERR_BUSY] = 1'b1;
      if (wasWr) begin
         mAge++;
         if (ack) mWr = 1'b0;
         else if (mAge == TO + 1) begin
            mWr = 1'b0;
            mErr[ERR_TIMEOUT] = 1'b1;
         end
      end
      if (ld == 8'h40 && !wasWr) begin
         mWr   = 1'b1;
         mAge  = 0;
         mAddr = oldAr;
         mData = busV;
      end
      mReg = nxt;
   endtask

   task automatic checkOutput();
      checkVal("r",          bif.r,          mReg[LD_R]);
      checkVal("ar",         bif.ar,         mReg[LD_AR]);
      checkVal("dr",         bif.dr,         mReg[LD_DR]);
      checkVal("ac",         bif.ac,         mReg[LD_AC]);
      checkVal("pc",         bif.pc,         mReg[LD_PC]);
      checkVal("ir",         bif.ir,         mReg[LD_IR]);
      checkVal("dram_addr",  bif.dram_addr,  mAddr);
      checkVal("dram_wdata", bif.dram_wdata, mData);
      checkVal("dram_we",    {15'b0, bif.dram_we}, {15'b0, mWr});
      checkVal("busy",       {15'b0, bif.busy},    {15'b0, mWr});
      checkVal("err",        {12'b0, bif.err},     {12'b0, mErr});
   endtask

   task automatic applyStimulus(input logic [15:0] busV, input logic [7:0] ld,
                                input logic [2:0] inc, input logic [1:0] clr, input logic ack);
      bif.bus_data  = busV;
      bif.load_ctrl = ld;
      bif.inc_ctrl  = inc;
      bif.clr_ctrl  = clr;
      bif.dram_ack  = ack;
      @(posedge clk);
      modelStep(busV, ld, inc, clr, ack);
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      bif.bus_data  = 16'h0000;
      bif.load_ctrl = 8'h00;
      bif.inc_ctrl  = 3'b000;
      bif.clr_ctrl  = 2'b00;
      bif.dram_ack  = 1'b0;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int weCycles;
      logic [7:0] ld;
      logic [15:0] bv;

      vecs[0]  = '{16'h1234, 8'h08, 3'b000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 4'h0};
      vecs[1]  = '{16'h00FF, 8'h10, 3'b000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h00FF, 4'h0};
      vecs[2]  = '{16'hAAAA, 8'h01, 3'b000, 2'b00, 16'hAAAA, 16'h0000, 16'h0000, 16'h1234, 16'h00FF, 4'h0};
      vecs[3]  = '{16'h0000, 8'h00, 3'b111, 2'b00, 16'hAAAB, 16'h0001, 16'h0000, 16'h1234, 16'h0100, 4'h0};
      vecs[4]  = '{16'h5555, 8'h01, 3'b100, 2'b11, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0100, 4'h0};
      vecs[5]  = '{16'h0040, 8'h02, 3'b010, 2'b00, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0100, 4'h0};
      vecs[6]  = '{16'h1357, 8'h04, 3'b000, 2'b00, 16'h0000, 16'h0040, 16'h1357, 16'h0000, 16'h0100, 4'h0};
      vecs[7]  = '{16'hFFFF, 8'h06, 3'b000, 2'b00, 16'h0000, 16'h0040, 16'h1357, 16'h0000, 16'h0100, 4'h1};
      vecs[8]  = '{16'h0000, 8'h80, 3'b000, 2'b00, 16'h0000, 16'h0040, 16'h1357, 16'h0000, 16'h0100, 4'h3};
      vecs[9]  = '{16'hFFFF, 8'h10, 3'b000, 2'b00, 16'h0000, 16'h0040, 16'h1357, 16'h0000, 16'hFFFF, 4'h3};
      vecs[10] = '{16'h0000, 8'h00, 3'b001, 2'b00, 16'h0000, 16'h0040, 16'h1357, 16'h0000, 16'h0000, 4'h3};

      rst_n = 1'b1;
      #2;
      doReset();
      checkVal("reset_pc", bif.pc, PCR);

      // Table-driven register behaviour
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].busV, vecs[i].ld, vecs[i].inc, vecs[i].clr, 1'b0);
         checkVal($sformatf("vec%0d_r", i),   bif.r,   vecs[i].eR);
         checkVal($sformatf("vec%0d_ar", i),  bif.ar,  vecs[i].eAr);
         checkVal($sformatf("vec%0d_dr", i),  bif.dr,  vecs[i].eDr);
         checkVal($sformatf("vec%0d_ac", i),  bif.ac,  vecs[i].eAc);
         checkVal($sformatf("vec%0d_pc", i),  bif.pc,  vecs[i].ePc);
         checkVal($sformatf("vec%0d_err", i), {12'b0, bif.err}, {12'b0, vecs[i].eErr});
      end

      // Handshaked write acked on the third strobe cycle
      doReset();
      applyStimulus(16'h0040, 8'h02, 3'b000, 2'b00, 1'b0);
      applyStimulus(16'hBEEF, 8'h40, 3'b000, 2'b00, 1'b0);
      weCycles = bif.dram_we ? 1 : 0;
      applyStimulus(16'h0000, 8'h00, 3'b000, 2'b00, 1'b0);
      if (bif.dram_we) weCycles++;
      applyStimulus(16'h0000, 8'h00, 3'b000, 2'b00, 1'b0);
      if (bif.dram_we) weCycles++;
      checkVal("wr_addr",  bif.dram_addr,  16'h0040);
      checkVal("wr_wdata", bif.dram_wdata, 16'hBEEF);
      applyStimulus(16'h0000, 8'h00, 3'b000, 2'b00, 1'b1);
      if (bif.dram_we) weCycles++;
      checkVal("ack_we_len", 16'(weCycles), 16'd3);
      checkVal("ack_err", {12'b0, bif.err}, 16'h0000);

      // Timeout with a dropped second request in flight
      applyStimulus(16'h1111, 8'h02, 3'b000, 2'b00, 1'b1);
      applyStimulus(16'h2222, 8'h40, 3'b000, 2'b00, 1'b0);
      weCycles = bif.dram_we ? 1 : 0;
      for (int c = 0; c < 40 && bif.dram_we; c++) begin
         ld = (c == 3) ? 8'h40 : 8'h00;
         bv = (c == 3) ? 16'h9999 : 16'h0000;
         applyStimulus(bv, ld, 3'b000, 2'b00, 1'b0);
         if (bif.dram_we) weCycles++;
         if (c == 3) begin
            checkVal("busy_req_addr", bif.dram_addr,  16'h1111);
            checkVal("busy_req_data", bif.dram_wdata, 16'h2222);
         end
      end
      checkVal("timeout_we_len", 16'(weCycles), 16'd16);
      checkVal("timeout_err", {12'b0, bif.err}, 16'h000C);
      applyStimulus(16'h0000, 8'h00, 3'b000, 2'b00, 1'b1);
      checkVal("err_sticky", {12'b0, bif.err}, 16'h000C);

      // Asynchronous reset in the middle of a write
      applyStimulus(16'h3333, 8'h40, 3'b000, 2'b00, 1'b0);
      applyStimulus(16'h0000, 8'h00, 3'b001, 2'b00, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkVal("async_we",   {15'b0, bif.dram_we}, 16'h0000);
      checkVal("async_busy", {15'b0, bif.busy},    16'h0000);
      checkOutput();
      #2;
      rst_n = 1'b1;
      applyStimulus(16'h0000, 8'h00, 3'b000, 2'b00, 1'b1);

      // Randomized traffic against the model
      for (int seg = 0; seg < 4; seg++) begin
         doReset();
         for (int n = 0; n < 120; n++) begin
            int sel;
            logic ack;
            sel = $urandom_range(0, 9);
            if (sel < 3) ld = 8'h00;
            else if (sel < 8) ld = 8'h01 << $urandom_range(0, 7);
            else ld = 8'($urandom);
            if (seg == 3) ack = 1'b0;
            else ack = ($urandom_range(0, 3) == 0);
            applyStimulus(16'($urandom), ld,
                          ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
                          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                          ack);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_load_unit.md
Name: bus_load_unit

Overview:
Destination side of the processor's shared 16-bit data bus. The bus multiplexer selects one source onto the bus. This block latches bus data into the selected destination register (R, AR, DR, AC, PC or IR), or issues a handshaked write into data RAM. It also performs register increment and clear micro-ops and reports illegal control words through sticky error flags.

Parameters:
WIDTH, 16, datapath and register width
PC_RESET, 16'h0000, PC value after reset
ACK_TIMEOUT, 15, maximum cycles dram_we waits for dram_ack before abort (range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bus_data  input  WIDTH  current bus value
load_ctrl  input  8  one-hot load select: b0 R, b1 AR, b2 DR, b3 AC, b4 PC, b5 IR, b6 DRAM write, b7 IRAM (not writable)
inc_ctrl  input  3  increment: b0 PC, b1 AR, b2 R
clr_ctrl  input  2  clear: b0 AC, b1 R
dram_ack  input  1  data RAM write accepted
r, ar, dr, ac, pc, ir  output  WIDTH each  register contents, fed back to bus mux
dram_addr  output  WIDTH  write address
dram_wdata  output  WIDTH  write data
dram_we  output  1  write strobe, held until ack or timeout
busy  output  1  DRAM write in progress
err  output  4  sticky: b0 multi-hot load, b1 IRAM write, b2 write while busy, b3 ack timeout

Behaviour:
- Reset (async, rst_n=0): r/ar/dr/ac/ir=0, pc=PC_RESET, dram_addr/dram_wdata=0, dram_we=0, busy=0, err=0, FSM=IDLE, timeout counter=0. Outputs take reset values immediately, not at the next edge. A reset mid-write drops the write; there is no ack wait after release.
- All updates occur on the rising clk edge. Register outputs reflect a load one cycle after load_ctrl is presented.
- load_ctrl=0: no load. Exactly one bit set: that destination is the target.
- Two or more bits set: nothing loads, no DRAM write starts, err[0] is set. inc/clr still apply.
- b7 alone: no state change; err[1] is set.
- Per-register priority: clear > load > increment. Example: clr_ctrl[1] together with load of R gives R=0.
- Increments are modulo 2^WIDTH (16'hFFFF+1 = 16'h0000), with no carry out.
- DRAM write FSM:
  - IDLE: on a legal b6 load, capture dram_addr=ar (pre-edge value) and dram_wdata=bus_data. Go to WRITE with dram_we=1, busy=1, counter=0.
  - WRITE: if dram_ack=1, go to IDLE with dram_we=0, busy=0. Otherwise the counter increments. When the counter reaches ACK_TIMEOUT with no ack, go to IDLE, set err[3], and deassert dram_we.
  - Ack is sampled on the same edge; minimum dram_we pulse is 1 cycle.
- A b6 request while busy=1 is dropped, sets err[2], and leaves the in-flight write untouched.
- A b6 request in the same cycle as an AR load/increment captures the old ar.
- dram_addr and dram_wdata are stable for the whole WRITE state.
- An ack arriving in IDLE is ignored.
- err bits clear only on reset.

Decomposition:
- Shared package holds:
  - load_ctrl bit index constants (LD_R..LD_IRAM), identical to the bus-mux select encoding.
  - inc/clr index constants.
  - err bit indices.
  - FSM state typedef (IDLE, WRITE).
- One natural sub-module: dram_write_ctrl, containing the FSM, timeout counter and address/data capture, with ports start, addr_in, data_in, ack, busy, we, timeout_pulse. The register bank stays in the top level.

Test Plan:
1. Reset, then bus_data=16'h1234 with load_ctrl=8'h08 for one cycle -> ac=16'h1234 next cycle; all other registers 0; pc=PC_RESET; err=0.
2. pc=16'hFFFF with inc_ctrl=3'b001 -> pc=16'h0000. Then clr_ctrl=2'b10 with load_ctrl=8'h01 and bus_data=16'hAAAA -> r=0.
3. ar=16'h0040, bus_data=16'hBEEF, load_ctrl=8'h40; dram_ack high 3 cycles later -> dram_addr=16'h0040, dram_wdata=16'hBEEF, dram_we/busy high exactly 3 cycles, then low, err=0.
4. Start a write, hold dram_ack=0 with ACK_TIMEOUT=15 -> dram_we drops after the 16th WRITE cycle, err[3]=1. A second b6 issued during WRITE -> err[2]=1 with addr/data unchanged.
5. load_ctrl=8'h06 -> ar and dr unchanged, err[0]=1. load_ctrl=8'h80 -> err[1]=1. Both remain set until rst_n pulse.
6. Assert rst_n=0 mid-WRITE, asynchronous to clk -> dram_we, busy and all registers reset without waiting for a clock edge.
